// File: rtl/dirty_tracker_array_pkg.sv
// -----------------------------------------------------------------------------
// dirty_tracker_array_pkg
// Shared types for the per-way dirty-bit tracker of the set-associative
// data cache.
//   dirty_trk_state_t : flush scanner state (IDLE -> SCAN -> DONE -> IDLE)
//   DT_WAYS_DEF / DT_INDEX_WIDTH_DEF : default geometry (2 ways, 8 sets)
// -----------------------------------------------------------------------------
package dirty_tracker_array_pkg;

   localparam int DT_WAYS_DEF        = 2;
   localparam int DT_INDEX_WIDTH_DEF = 3;

   typedef enum logic [1:0] {
      DT_IDLE = 2'd0,
      DT_SCAN = 2'd1,
      DT_DONE = 2'd2
   } dirty_trk_state_t;

endpackage : dirty_tracker_array_pkg

// File: rtl/dirty_tracker_array_if.sv
// -----------------------------------------------------------------------------
// dirty_tracker_array_if
// Bundle between the cache controller (master) and the dirty tracker (slave).
//   host side  : index, way, set_dirty, clear_dirty -> dirty_out
//   flush side : flush_req, flush_ready -> flush_valid, flush_index,
//                flush_way, flush_done, busy
//   dirty_count: present only when DIRTY_TRACKER_COUNT_EN is defined
// -----------------------------------------------------------------------------
interface dirty_tracker_array_if #(
   parameter int WAYS        = 2,
   parameter int INDEX_WIDTH = 3
);
   localparam int WAY_WIDTH = $clog2(WAYS);

   logic [INDEX_WIDTH-1:0] index;
   logic [WAY_WIDTH-1:0]   way;
   logic                   set_dirty;
   logic                   clear_dirty;
   logic [WAYS-1:0]        dirty_out;
   logic                   flush_req;
   logic                   flush_valid;
   logic [INDEX_WIDTH-1:0] flush_index;
   logic [WAY_WIDTH-1:0]   flush_way;
   logic                   flush_ready;
   logic                   flush_done;
   logic                   busy;
`ifdef DIRTY_TRACKER_COUNT_EN
   logic [INDEX_WIDTH+WAY_WIDTH:0] dirty_count;

   modport master (
      output index, way, set_dirty, clear_dirty, flush_req, flush_ready,
      input  dirty_out, flush_valid, flush_index, flush_way, flush_done, busy,
             dirty_count
   );
   modport slave (
      input  index, way, set_dirty, clear_dirty, flush_req, flush_ready,
      output dirty_out, flush_valid, flush_index, flush_way, flush_done, busy,
             dirty_count
   );
`else
   modport master (
      output index, way, set_dirty, clear_dirty, flush_req, flush_ready,
      input  dirty_out, flush_valid, flush_index, flush_way, flush_done, busy
   );
   modport slave (
      input  index, way, set_dirty, clear_dirty, flush_req, flush_ready,
      output dirty_out, flush_valid, flush_index, flush_way, flush_done, busy
   );
`endif

endinterface : dirty_tracker_array_if

// File: rtl/dirty_tracker_array_scan_ptr.sv
// -----------------------------------------------------------------------------
// dirty_scan_ptr
// (set, way) walk pointer for the flush scanner. Way is the low field so the
// walk is set-major: way increments first, then set.
//   clk, reset : clock, synchronous active-high reset
//   clr        : return pointer to (0, 0)
//   inc        : advance to the next entry
//   set_idx    : current set
//   way_idx    : current way
//   last       : pointer is at (SETS-1, WAYS-1)
// -----------------------------------------------------------------------------
module dirty_scan_ptr #(
   parameter int WAYS        = 2,
   parameter int INDEX_WIDTH = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clr,
   input  logic                         inc,
   output logic [INDEX_WIDTH-1:0]       set_idx,
   output logic [$clog2(WAYS)-1:0]      way_idx,
   output logic                         last
);
   localparam int WAY_WIDTH = $clog2(WAYS);
   localparam int PW        = INDEX_WIDTH + WAY_WIDTH;

   logic [PW-1:0] ptr;

   always_ff @(posedge clk) begin
      if (reset || clr) ptr <= '0;
      else if (inc)     ptr <= ptr + PW'(1);
   end

   assign {set_idx, way_idx} = ptr;
   assign last               = &ptr;

endmodule : dirty_scan_ptr

// File: rtl/dirty_tracker_array.sv
// -----------------------------------------------------------------------------
// dirty_tracker_array
// Per-way dirty-bit store with a built-in flush scanner. The scanner walks
// every (set, way), presents each dirty entry on a valid/ready handshake and
// clears it when the controller accepts it.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : dirty_tracker_array_if.slave (host writes, dirty_out, flush
//           handshake, flush_done, busy, optional dirty_count)
// Build option: DIRTY_TRACKER_COUNT_EN adds a dirty-entry counter, the
// dirty_count output and early termination of the scan when nothing is dirty.
// -----------------------------------------------------------------------------
module dirty_tracker_array
   import dirty_tracker_array_pkg::*;
#(
   parameter int WAYS        = DT_WAYS_DEF,
   parameter int INDEX_WIDTH = DT_INDEX_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   dirty_tracker_array_if.slave  bus
);
   localparam int WAY_WIDTH = $clog2(WAYS);
   localparam int SETS      = 2 ** INDEX_WIDTH;

   dirty_trk_state_t       state;
   logic [WAYS-1:0]        bits [SETS];
   logic [INDEX_WIDTH-1:0] ptr_set;
   logic [WAY_WIDTH-1:0]   ptr_way;
   logic                   ptr_last;
   logic                   ptr_clr;
   logic                   ptr_inc;
   logic                   cur_dirty;
   logic                   accept;
   logic                   scan_end;
   logic                   host_set;
   logic                   host_clr;
   logic                   host_bit;

`ifdef DIRTY_TRACKER_COUNT_EN
   localparam int CW = INDEX_WIDTH + WAY_WIDTH + 1;
   logic [CW-1:0] count;
`endif

   dirty_scan_ptr #(
      .WAYS        (WAYS),
      .INDEX_WIDTH (INDEX_WIDTH)
   ) u_ptr (
      .clk     (clk),
      .reset   (reset),
      .clr     (ptr_clr),
      .inc     (ptr_inc),
      .set_idx (ptr_set),
      .way_idx (ptr_way),
      .last    (ptr_last)
   );

   // NOTE: combinational logic uses blocking '=' with every signal given a
   // value up front, so no path through the block can infer a latch.
   always_comb begin
      cur_dirty = bits[ptr_set][ptr_way];
      accept    = (state == DT_SCAN) && cur_dirty && bus.flush_ready;
      ptr_clr   = (state != DT_SCAN);
      // A clean entry advances at once; a dirty one waits for acceptance.
      ptr_inc   = (state == DT_SCAN) && (!cur_dirty || bus.flush_ready);
`ifdef DIRTY_TRACKER_COUNT_EN
      scan_end  = (state == DT_SCAN) && ((count == '0) || (ptr_inc && ptr_last));
`else
      scan_end  = ptr_inc && ptr_last;
`endif
      // Host writes only land while idle; set wins over clear.
      host_set  = (state == DT_IDLE) && bus.set_dirty;
      host_clr  = (state == DT_IDLE) && bus.clear_dirty && !bus.set_dirty;
      host_bit  = bits[bus.index][bus.way];
   end

   // NOTE: the bit array is cleared by reset because a flush after reset must
   // see a clean cache; sequential state is updated with non-blocking '<='.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= DT_IDLE;
         for (int s = 0; s < SETS; s++) bits[s] <= '0;
      end else begin
         case (state)
            DT_IDLE: if (bus.flush_req) state <= DT_SCAN;
            DT_SCAN: if (scan_end)      state <= DT_DONE;
            DT_DONE:                    state <= DT_IDLE;
            default:                    state <= DT_IDLE;
         endcase

         if (host_set)      bits[bus.index][bus.way] <= 1'b1;
         else if (host_clr) bits[bus.index][bus.way] <= 1'b0;

         if (accept) bits[ptr_set][ptr_way] <= 1'b0;
      end
   end

`ifdef DIRTY_TRACKER_COUNT_EN
   // Counts only real bit transitions; host writes and accepts never coincide
   // because host writes are blocked outside IDLE.
   always_ff @(posedge clk) begin
      if (reset)                                count <= '0;
      else if (host_set && !host_bit)           count <= count + CW'(1);
      else if ((host_clr && host_bit) || accept) count <= count - CW'(1);
   end

   assign bus.dirty_count = count;
`endif

   assign bus.dirty_out   = bits[bus.index];
   assign bus.flush_valid = (state == DT_SCAN) && cur_dirty;
   assign bus.flush_index = ptr_set;
   assign bus.flush_way   = ptr_way;
   assign bus.flush_done  = (state == DT_DONE);
   assign bus.busy        = (state != DT_IDLE);

endmodule : dirty_tracker_array
